muldiv_unit: RTL and testbench

- Multi-cycle unsigned multiply/divide execution unit feeding the 4x8 register file write port.
- Consumes the two read-port operands plus a destination register index; iterates over WIDTH cycles, then issues a single-cycle write-back (wb_en/wb_reg/wb_value) that drives write_en/write_reg/write_value directly.
- Lets the core run MUL/DIV/MOD without a combinational multiplier or divider in the ALU path; the sequencer stalls on busy.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_step.sv | 37 +++
 rtl/muldiv_unit.sv | 121 ++++++++++++
 tb/tb_muldiv_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the multi-cycle multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 8;
    localparam int unsigned DEFAULT_REG_AW = 2;

    typedef enum logic [1:0] {
        OP_MUL_LO,
        OP_MUL_HI,
        OP_DIV,
        OP_MOD
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WB
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequential datapath.
// Multiply: hi/lo form the running product with the multiplier in lo; the
// product is shifted right one bit per step after a conditional add.
// Divide: hi holds the partial remainder and lo the dividend, which turns
// into the quotient as bits shift in from the right, MSB first.
module muldiv_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Shift-add or trial-subtract; a zero divisor always "fits", which
    // yields an all-ones quotient and leaves the dividend as remainder.
    always_comb begin
        sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : (WIDTH+1)'(0));
        rem_sh = {hi_i, lo_i[WIDTH-1]};
        fits   = (rem_sh >= {1'b0, opnd_i});
        diff   = rem_sh[WIDTH-1:0] - opnd_i;
        hi_o   = sum[WIDTH:1];
        lo_o   = {sum[0], lo_i[WIDTH-1:1]};
        if (is_div_i) begin
            hi_o = fits ? diff : rem_sh[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], fits};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned MUL/DIV/MOD unit with a one-cycle register write-back.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned REG_AW = DEFAULT_REG_AW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  src_a,
    input  logic [WIDTH-1:0]  src_b,
    input  logic [REG_AW-1:0] dest_reg,
    output logic              ready,
    output logic              busy,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_reg,
    output logic [WIDTH-1:0]  wb_value,
    output logic              div_by_zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e              state_q;
    op_e                 op_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WIDTH-1:0]    opnd_q, hi_q, lo_q;
    logic [WIDTH-1:0]    hi_d, lo_d;
    logic [REG_AW-1:0]   dest_q;
    logic                ready_q, busy_q, wb_en_q, dbz_q;
    logic [REG_AW-1:0]   wb_reg_q;
    logic [WIDTH-1:0]    wb_value_q;
    logic                is_div_q, is_div_in;
    logic [WIDTH-1:0]    result_d;

    assign is_div_q  = (op_q == OP_DIV) || (op_q == OP_MOD);
    assign is_div_in = op[1];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .opnd_i   (opnd_q),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .hi_o     (hi_d),
        .lo_o     (lo_d)
    );

    // Select the write-back value from the state after the final iteration.
    always_comb begin
        result_d = lo_d;
        case (op_q)
            OP_MUL_HI: result_d = hi_d;
            OP_MOD:    result_d = hi_d;
            default:   result_d = lo_d;
        endcase
    end

    // Sequencer, operand/accumulator registers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_MUL_LO;
            cnt_q      <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            dest_q     <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            wb_en_q    <= 1'b0;
            dbz_q      <= 1'b0;
            wb_reg_q   <= '0;
            wb_value_q <= '0;
        end else begin
            wb_en_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q    <= S_WB;
                        ready_q    <= 1'b1;
                        wb_en_q    <= 1'b1;
                        wb_reg_q   <= dest_q;
                        wb_value_q <= result_d;
                        dbz_q      <= is_div_q && (opnd_q == '0);
                    end
                end
                default: begin
                    // IDLE and WB both accept a new operation.
                    if (start) begin
                        state_q <= S_RUN;
                        op_q    <= op_e'(op);
                        dest_q  <= dest_reg;
                        cnt_q   <= '0;
                        hi_q    <= '0;
                        opnd_q  <= is_div_in ? src_b : src_a;
                        lo_q    <= is_div_in ? src_a : src_b;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign ready       = ready_q;
    assign busy        = busy_q;
    assign wb_en       = wb_en_q;
    assign wb_reg      = wb_reg_q;
    assign wb_value    = wb_value_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed and random ops against an arithmetic model.
module tb_muldiv_unit;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned REG_AW = 2;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [1:0]        op;
    logic [WIDTH-1:0]  src_a, src_b;
    logic [REG_AW-1:0] dest_reg;
    logic              ready, busy, wb_en, div_by_zero;
    logic [REG_AW-1:0] wb_reg;
    logic [WIDTH-1:0]  wb_value;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] d;
        bit         chain;
    } op_t;

    op_t        q[$];
    logic       dbz_exp = 1'b0;
    logic [7:0] last_val = 8'h00;
    logic [1:0] last_reg = 2'd0;

    muldiv_unit #(.WIDTH(WIDTH), .REG_AW(REG_AW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .dest_reg    (dest_reg),
        .ready       (ready),
        .busy        (busy),
        .wb_en       (wb_en),
        .wb_reg      (wb_reg),
        .wb_value    (wb_value),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Arithmetic reference: plain integer multiply/divide with the zero-divisor rules.
    function automatic logic [7:0] ref_val(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        int unsigned pa, pb, p;
        pa = a;
        pb = b;
        p  = pa * pb;
        case (o)
            2'd0:    return 8'(p);
            2'd1:    return 8'(p >> 8);
            2'd2:    return (pb == 0) ? 8'hFF : 8'(pa / pb);
            default: return (pb == 0) ? a : 8'(pa % pb);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        src_a    = 8'($urandom);
        src_b    = 8'($urandom);
        op       = 2'($urandom);
        dest_reg = 2'($urandom);
    endtask

    task automatic drive_start(input op_t t);
        start    = 1'b1;
        op       = t.op;
        src_a    = t.a;
        src_b    = t.b;
        dest_reg = t.d;
        tick();
        start = 1'b0;
        scramble();
    endtask

    // Called one cycle after the start edge; junk start pulses during RUN must be ignored.
    task automatic wait_wb(input op_t t, output bit ok);
        int k;
        k  = 1;
        ok = 1'b0;
        while (k <= 3 * WIDTH) begin
            if (wb_en) begin
                ok = 1'b1;
                break;
            end
            check("run_busy", 32'(busy), 32'd1);
            check("run_ready", 32'(ready), 32'd0);
            start = 1'($urandom_range(0, 1));
            scramble();
            tick();
            k++;
        end
        start = 1'b0;
        if (!ok) begin
            check("wb_seen", 32'(wb_en), 32'd1);
            return;
        end
        last_val = ref_val(t.op, t.a, t.b);
        last_reg = t.d;
        dbz_exp  = t.op[1] && (t.b == 8'h00);
        check("latency", 32'(k), 32'(WIDTH + 1));
        check("wb_reg", 32'(wb_reg), 32'(last_reg));
        check("wb_value", 32'(wb_value), 32'(last_val));
        check("div_by_zero", 32'(div_by_zero), 32'(dbz_exp));
        check("wb_ready", 32'(ready), 32'd1);
        check("wb_busy", 32'(busy), 32'd1);
    endtask

    task automatic check_idle();
        check("idle_wb_en", 32'(wb_en), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'(ready), 32'd1);
        check("held_value", 32'(wb_value), 32'(last_val));
        check("held_reg", 32'(wb_reg), 32'(last_reg));
        check("held_dbz", 32'(div_by_zero), 32'(dbz_exp));
    endtask

    // Run every queued op; chained ops are started in the previous op's WB cycle.
    task automatic run_seq();
        bit  ok;
        op_t t, nx;
        t = q.pop_front();
        check("start_ready", 32'(ready), 32'd1);
        drive_start(t);
        forever begin
            wait_wb(t, ok);
            if (!ok) begin
                q.delete();
                return;
            end
            if (q.size() == 0) break;
            nx = q.pop_front();
            if (!nx.chain) begin
                tick();
                check_idle();
            end
            drive_start(nx);
            t = nx;
        end
        tick();
        check_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_wb_en"}, 32'(wb_en), 32'd0);
        check({tag, "_wb_reg"}, 32'(wb_reg), 32'd0);
        check({tag, "_wb_value"}, 32'(wb_value), 32'd0);
        check({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
    endtask

    initial begin
        int  strobes;
        op_t t;

        reset_n  = 1'b0;
        start    = 1'b0;
        op       = 2'd0;
        src_a    = '0;
        src_b    = '0;
        dest_reg = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Directed cases, ending with a back-to-back pair.
        q.push_back('{2'd0, 8'h0D, 8'h0B, 2'd2, 1'b0});
        q.push_back('{2'd1, 8'hC8, 8'hC8, 2'd1, 1'b0});
        q.push_back('{2'd0, 8'hC8, 8'hC8, 2'd3, 1'b0});
        q.push_back('{2'd1, 8'hFF, 8'hFF, 2'd0, 1'b0});
        q.push_back('{2'd0, 8'hFF, 8'hFF, 2'd1, 1'b0});
        q.push_back('{2'd2, 8'h64, 8'h07, 2'd2, 1'b0});
        q.push_back('{2'd3, 8'h64, 8'h07, 2'd3, 1'b0});
        q.push_back('{2'd2, 8'h05, 8'h09, 2'd0, 1'b0});
        q.push_back('{2'd3, 8'h05, 8'h09, 2'd1, 1'b0});
        q.push_back('{2'd2, 8'h37, 8'h00, 2'd2, 1'b0});
        q.push_back('{2'd3, 8'h37, 8'h00, 2'd3, 1'b0});
        q.push_back('{2'd0, 8'h01, 8'h01, 2'd0, 1'b0});
        q.push_back('{2'd2, 8'h80, 8'h03, 2'd1, 1'b1});
        q.push_back('{2'd3, 8'hFE, 8'h00, 2'd2, 1'b1});
        run_seq();

        // Reset in RUN cycle 4, released in cycle 6: no write-back may appear.
        t = '{2'd0, 8'h21, 8'h05, 2'd3, 1'b0};
        drive_start(t);
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        tick();
        tick();
        reset_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 16; i++) begin
            if (wb_en) strobes++;
            tick();
        end
        check("abort_no_wb", 32'(strobes), 32'd0);
        check_reset_outputs("after_abort");
        dbz_exp  = 1'b0;
        last_val = 8'h00;
        last_reg = 2'd0;
        q.push_back('{2'd1, 8'h9A, 8'h77, 2'd1, 1'b0});
        run_seq();

        // Random ops, random chaining, occasional zero divisor.
        for (int i = 0; i < 60; i++) begin
            t.op    = 2'($urandom);
            t.a     = 8'($urandom);
            t.b     = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            t.d     = 2'($urandom);
            t.chain = 1'($urandom_range(0, 1));
            q.push_back(t);
        end
        run_seq();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
